// File: rtl/host_loader.sv
// Host command front end: parses host byte frames, issues single Wishbone cycles,
// owns the processor control register and returns status/read data as reply bytes.
module host_loader #(
    parameter int unsigned ADDRESS_WIDTH = 24,
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter logic [15:0] CONTROL_RESET = 16'h0001
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [7:0]               rxData,
    input  logic                     rxValid,
    output logic                     rxReady,
    output logic [7:0]               txData,
    output logic                     txValid,
    input  logic                     txReady,
    output logic [ADDRESS_WIDTH-1:0] wbAdrO,
    output logic [15:0]              wbDatO,
    input  logic [15:0]              wbDatI,
    output logic                     wbCycO,
    output logic                     wbStbO,
    output logic                     wbWeO,
    input  logic                     wbAckI,
    output logic [15:0]              controlReg,
    input  logic [15:0]              statusReg
);

    localparam int unsigned TO_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_CTRL  = 8'h43;
    localparam logic [7:0] OP_STAT  = 8'h53;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_UNK  = 8'h3F;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    typedef enum logic [1:0] {
        IDLE,
        ARGS,
        BUS,
        REPLY
    } stateT;

    stateT                    state, stateNext;
    logic [7:0]               opcode, opcodeNext;
    logic [31:0]              argShift, argShiftNext;
    logic [2:0]               argCnt, argCntNext;
    logic [TO_W-1:0]          toCnt, toCntNext;
    logic                     busReq, busReqNext;
    logic                     weNext;
    logic [ADDRESS_WIDTH-1:0] adrNext;
    logic [15:0]              datNext;
    logic [15:0]              ctrlNext;
    logic [7:0]               txDataNext;
    logic                     txValidNext;
    logic [7:0]               secondByte, secondByteNext;
    logic                     hasSecond, hasSecondNext;
    logic                     rxReadyNext;
    logic                     rxFire;
    logic [39:0]              shifted;
    logic [23:0]              addrW, addrR;

    assign wbCycO = busReq;
    assign wbStbO = busReq;

    assign rxFire  = rxValid && rxReady;
    assign shifted = {argShift, rxData};
    assign addrW   = shifted[39:16];
    assign addrR   = shifted[23:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            opcode     <= 8'h00;
            argShift   <= 32'h0;
            argCnt     <= 3'd0;
            toCnt      <= '0;
            busReq     <= 1'b0;
            wbWeO      <= 1'b0;
            wbAdrO     <= '0;
            wbDatO     <= 16'h0;
            controlReg <= CONTROL_RESET;
            txData     <= 8'h00;
            txValid    <= 1'b0;
            secondByte <= 8'h00;
            hasSecond  <= 1'b0;
            rxReady    <= 1'b0;
        end else begin
            state      <= stateNext;
            opcode     <= opcodeNext;
            argShift   <= argShiftNext;
            argCnt     <= argCntNext;
            toCnt      <= toCntNext;
            busReq     <= busReqNext;
            wbWeO      <= weNext;
            wbAdrO     <= adrNext;
            wbDatO     <= datNext;
            controlReg <= ctrlNext;
            txData     <= txDataNext;
            txValid    <= txValidNext;
            secondByte <= secondByteNext;
            hasSecond  <= hasSecondNext;
            rxReady    <= rxReadyNext;
        end
    end

    // Frame parser, bus sequencer and reply generator
    always_comb begin
        stateNext      = state;
        opcodeNext     = opcode;
        argShiftNext   = argShift;
        argCntNext     = argCnt;
        toCntNext      = toCnt + TO_W'(1);
        busReqNext     = busReq;
        weNext         = wbWeO;
        adrNext        = wbAdrO;
        datNext        = wbDatO;
        ctrlNext       = controlReg;
        txDataNext     = txData;
        txValidNext    = txValid;
        secondByteNext = secondByte;
        hasSecondNext  = hasSecond;

        case (state)
            IDLE: begin
                if (rxFire) begin
                    opcodeNext = rxData;
                    case (rxData)
                        OP_WRITE: begin
                            argCntNext = 3'd5;
                            stateNext  = ARGS;
                        end
                        OP_READ: begin
                            argCntNext = 3'd3;
                            stateNext  = ARGS;
                        end
                        OP_CTRL: begin
                            argCntNext = 3'd2;
                            stateNext  = ARGS;
                        end
                        OP_STAT: begin
                            // One sample of statusReg feeds both reply bytes
                            txDataNext     = statusReg[15:8];
                            secondByteNext = statusReg[7:0];
                            hasSecondNext  = 1'b1;
                            txValidNext    = 1'b1;
                            stateNext      = REPLY;
                        end
                        default: begin
                            txDataNext    = RSP_UNK;
                            hasSecondNext = 1'b0;
                            txValidNext   = 1'b1;
                            stateNext     = REPLY;
                        end
                    endcase
                end
            end

            ARGS: begin
                if (rxFire) begin
                    argShiftNext = shifted[31:0];
                    argCntNext   = argCnt - 3'd1;
                    if (argCnt == 3'd1) begin
                        case (opcode)
                            OP_CTRL: begin
                                ctrlNext      = shifted[15:0];
                                txDataNext    = RSP_OK;
                                hasSecondNext = 1'b0;
                                txValidNext   = 1'b1;
                                stateNext     = REPLY;
                            end
                            OP_WRITE: begin
                                busReqNext = 1'b1;
                                weNext     = 1'b1;
                                adrNext    = addrW[ADDRESS_WIDTH-1:0];
                                datNext    = shifted[15:0];
                                toCntNext  = '0;
                                stateNext  = BUS;
                            end
                            default: begin
                                busReqNext = 1'b1;
                                weNext     = 1'b0;
                                adrNext    = addrR[ADDRESS_WIDTH-1:0];
                                toCntNext  = '0;
                                stateNext  = BUS;
                            end
                        endcase
                    end
                end
            end

            BUS: begin
                // Ack takes priority over a timeout reached in the same cycle
                if (wbAckI) begin
                    busReqNext  = 1'b0;
                    weNext      = 1'b0;
                    txValidNext = 1'b1;
                    stateNext   = REPLY;
                    if (wbWeO) begin
                        txDataNext    = RSP_OK;
                        hasSecondNext = 1'b0;
                    end else begin
                        txDataNext     = wbDatI[15:8];
                        secondByteNext = wbDatI[7:0];
                        hasSecondNext  = 1'b1;
                    end
                end else if (toCnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    busReqNext    = 1'b0;
                    weNext        = 1'b0;
                    txDataNext    = RSP_ERR;
                    hasSecondNext = 1'b0;
                    txValidNext   = 1'b1;
                    stateNext     = REPLY;
                end
            end

            REPLY: begin
                if (txValid && txReady) begin
                    if (hasSecond) begin
                        txDataNext    = secondByte;
                        hasSecondNext = 1'b0;
                    end else begin
                        txValidNext = 1'b0;
                        stateNext   = IDLE;
                    end
                end
            end

            default: stateNext = IDLE;
        endcase

        rxReadyNext = (stateNext == IDLE) || (stateNext == ARGS);
    end

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: write, read with back-pressure, control/status,
// timeout and ack-at-limit, unknown opcode and mid-frame reset.
module tb_host_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [23:0] wbAdrO;
    logic [15:0] wbDatO;
    logic [15:0] wbDatI = 16'h0;
    logic        wbCycO;
    logic        wbStbO;
    logic        wbWeO;
    logic        wbAckI = 1'b0;
    logic [15:0] controlReg;
    logic [15:0] statusReg;

    int compared   = 0;
    int mismatched = 0;

    int          ackOn     = 0;
    logic [15:0] slaveData = 16'h0;
    int          stbRun    = 0;
    int          stbLast   = 0;

    host_loader #(
        .ADDRESS_WIDTH(24),
        .ACK_TIMEOUT  (4),
        .CONTROL_RESET(16'h0001)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rxReady   (rxReady),
        .txData    (txData),
        .txValid   (txValid),
        .txReady   (txReady),
        .wbAdrO    (wbAdrO),
        .wbDatO    (wbDatO),
        .wbDatI    (wbDatI),
        .wbCycO    (wbCycO),
        .wbStbO    (wbStbO),
        .wbWeO     (wbWeO),
        .wbAckI    (wbAckI),
        .controlReg(controlReg),
        .statusReg (statusReg)
    );

    always #5 clk = ~clk;

    // Slave: acks on the ackOn-th strobe cycle (0 = never), records run length
    always @(negedge clk) begin
        if (wbStbO) begin
            stbRun = stbRun + 1;
            wbAckI = (ackOn != 0) && (stbRun == ackOn);
            wbDatI = slaveData;
        end else begin
            if (stbRun != 0) stbLast = stbRun;
            stbRun = 0;
            wbAckI = 1'b0;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        rxData  = b;
        rxValid = 1'b1;
        while (!rxReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rxReady) begin
            compared++;
            mismatched++;
            $display("FAIL send_wait: rxReady stayed %0b for byte %02h", rxReady, b);
        end
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic recvBytes(input int n, output logic [15:0] got, output int cnt);
        got = 16'h0;
        cnt = 0;
        txReady = 1'b1;
        for (int i = 0; i < 100 && cnt < n; i++) begin
            if (txValid) begin
                got = {got[7:0], txData};
                cnt++;
            end
            @(negedge clk);
        end
        txReady = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; rxValid = 1'b0; rxData = 8'h00; txReady = 1'b0; statusReg = 16'h0;
        repeat (3) @(negedge clk);
        compared++; if (rxReady !== 1'b0) begin mismatched++; $display("FAIL reset_rxReady: got %0b want 0", rxReady); end
        compared++; if ({txValid, txData} !== 9'h0) begin mismatched++; $display("FAIL reset_tx: got %0b/%02h want 0/00", txValid, txData); end
        compared++; if ({wbCycO, wbStbO, wbWeO} !== 3'b000) begin mismatched++; $display("FAIL reset_wbctl: got %03b want 000", {wbCycO, wbStbO, wbWeO}); end
        compared++; if ({wbAdrO, wbDatO} !== 40'h0) begin mismatched++; $display("FAIL reset_wbbus: got %06h/%04h want 0/0", wbAdrO, wbDatO); end
        compared++; if (controlReg !== 16'h0001) begin mismatched++; $display("FAIL reset_ctrl: got %04h want 0001", controlReg); end
        rstN = 1'b1;
        @(negedge clk);
        compared++; if (rxReady !== 1'b1) begin mismatched++; $display("FAIL reset_release_rxReady: got %0b want 1", rxReady); end
    endtask

    task automatic test_write();
        logic [15:0] got;
        int cnt;
        ackOn = 2;
        sendByte(8'h57); sendByte(8'h01); sendByte(8'h00); sendByte(8'h05); sendByte(8'h12); sendByte(8'h34);
        compared++; if ({wbCycO, wbStbO, wbWeO} !== 3'b111) begin mismatched++; $display("FAIL wr_start: got %03b want 111", {wbCycO, wbStbO, wbWeO}); end
        compared++; if (wbAdrO !== 24'h010005 || wbDatO !== 16'h1234) begin mismatched++; $display("FAIL wr_adrdat: got %06h/%04h want 010005/1234", wbAdrO, wbDatO); end
        compared++; if (rxReady !== 1'b0) begin mismatched++; $display("FAIL wr_rxReady_bus: got %0b want 0", rxReady); end
        @(negedge clk);
        compared++; if (wbStbO !== 1'b1 || wbAdrO !== 24'h010005 || wbDatO !== 16'h1234) begin mismatched++; $display("FAIL wr_hold: got stb %0b %06h/%04h want 1 010005/1234", wbStbO, wbAdrO, wbDatO); end
        @(negedge clk);
        compared++; if ({wbCycO, wbStbO, wbWeO} !== 3'b000) begin mismatched++; $display("FAIL wr_end: got %03b want 000", {wbCycO, wbStbO, wbWeO}); end
        compared++; if (txValid !== 1'b1 || txData !== 8'h4B) begin mismatched++; $display("FAIL wr_txfirst: got %0b/%02h want 1/4b", txValid, txData); end
        recvBytes(1, got, cnt);
        compared++; if (cnt !== 1 || got[7:0] !== 8'h4B) begin mismatched++; $display("FAIL wr_reply: got %0d bytes %04h want 1 byte 4b", cnt, got); end
        compared++; if (txValid !== 1'b0 || rxReady !== 1'b1) begin mismatched++; $display("FAIL wr_idle: got txValid %0b rxReady %0b want 0 1", txValid, rxReady); end
        compared++; if (stbLast !== 2) begin mismatched++; $display("FAIL wr_stb_len: got %0d want 2", stbLast); end
    endtask

    task automatic test_read_backpressure();
        logic [15:0] got;
        int cnt;
        int holdBad;
        ackOn = 1; slaveData = 16'hBEEF; holdBad = 0;
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h07);
        compared++; if ({wbStbO, wbWeO} !== 2'b10 || wbAdrO !== 24'h000007) begin mismatched++; $display("FAIL rd_start: got stb/we %02b adr %06h want 10 000007", {wbStbO, wbWeO}, wbAdrO); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (txValid !== 1'b1 || txData !== 8'hBE || wbStbO !== 1'b0) holdBad++;
        end
        compared++; if (holdBad !== 0) begin mismatched++; $display("FAIL rd_hold: %0d of 5 cycles lost BE (now %0b/%02h)", holdBad, txValid, txData); end
        recvBytes(2, got, cnt);
        compared++; if (cnt !== 2 || got !== 16'hBEEF) begin mismatched++; $display("FAIL rd_reply: got %0d bytes %04h want 2 bytes beef", cnt, got); end
        compared++; if (txValid !== 1'b0 || rxReady !== 1'b1) begin mismatched++; $display("FAIL rd_idle: got txValid %0b rxReady %0b want 0 1", txValid, rxReady); end
        compared++; if (stbLast !== 1) begin mismatched++; $display("FAIL rd_stb_len: got %0d want 1", stbLast); end
        compared++; if (controlReg !== 16'h0001) begin mismatched++; $display("FAIL rd_ctrl_untouched: got %04h want 0001", controlReg); end
    endtask

    task automatic test_control_status();
        logic [15:0] got;
        int cnt;
        sendByte(8'h43); sendByte(8'hA5); sendByte(8'h3C);
        compared++; if (controlReg !== 16'hA53C) begin mismatched++; $display("FAIL ctrl_a53c: got %04h want a53c", controlReg); end
        compared++; if (txValid !== 1'b1 || txData !== 8'h4B) begin mismatched++; $display("FAIL ctrl_txfirst: got %0b/%02h want 1/4b", txValid, txData); end
        recvBytes(1, got, cnt);
        sendByte(8'h43); sendByte(8'h00); sendByte(8'h00);
        compared++; if (controlReg !== 16'h0000) begin mismatched++; $display("FAIL ctrl_zero: got %04h want 0000", controlReg); end
        recvBytes(1, got, cnt);
        compared++; if (cnt !== 1 || got[7:0] !== 8'h4B) begin mismatched++; $display("FAIL ctrl_reply: got %0d bytes %04h want 1 byte 4b", cnt, got); end
        statusReg = 16'h0005;
        sendByte(8'h53);
        statusReg = 16'hFFFF;
        recvBytes(2, got, cnt);
        compared++; if (cnt !== 2 || got !== 16'h0005) begin mismatched++; $display("FAIL status_reply: got %0d bytes %04h want 2 bytes 0005", cnt, got); end
        compared++; if (txValid !== 1'b0 || rxReady !== 1'b1) begin mismatched++; $display("FAIL status_idle: got txValid %0b rxReady %0b want 0 1", txValid, rxReady); end
    endtask

    task automatic test_timeout();
        logic [15:0] got;
        int cnt;
        int n;
        ackOn = 0; n = 0;
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        while (wbStbO && n < 20) begin
            n++;
            @(negedge clk);
        end
        compared++; if (n !== 4) begin mismatched++; $display("FAIL to_stb_len: got %0d want 4", n); end
        compared++; if (txValid !== 1'b1 || txData !== 8'h45 || wbCycO !== 1'b0) begin mismatched++; $display("FAIL to_err: got %0b/%02h cyc %0b want 1/45 cyc 0", txValid, txData, wbCycO); end
        recvBytes(1, got, cnt);
        compared++; if (cnt !== 1 || got[7:0] !== 8'h45) begin mismatched++; $display("FAIL to_reply: got %0d bytes %04h want 1 byte 45", cnt, got); end
        compared++; if (txValid !== 1'b0 || rxReady !== 1'b1) begin mismatched++; $display("FAIL to_single: got txValid %0b rxReady %0b want 0 1", txValid, rxReady); end
        // Ack arriving on the last allowed cycle still succeeds
        ackOn = 4; slaveData = 16'h1357;
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h09);
        recvBytes(2, got, cnt);
        compared++; if (cnt !== 2 || got !== 16'h1357) begin mismatched++; $display("FAIL to_ack_at_limit: got %0d bytes %04h want 2 bytes 1357", cnt, got); end
        compared++; if (stbLast !== 4) begin mismatched++; $display("FAIL to_ack_stb_len: got %0d want 4", stbLast); end
    endtask

    task automatic test_unknown_and_reset();
        logic [15:0] got;
        int cnt;
        int txBad;
        txBad = 0;
        sendByte(8'h99);
        recvBytes(1, got, cnt);
        compared++; if (cnt !== 1 || got[7:0] !== 8'h3F) begin mismatched++; $display("FAIL unk_reply: got %0d bytes %04h want 1 byte 3f", cnt, got); end
        compared++; if (rxReady !== 1'b1 || txValid !== 1'b0) begin mismatched++; $display("FAIL unk_idle: got rxReady %0b txValid %0b want 1 0", rxReady, txValid); end
        sendByte(8'h57); sendByte(8'h01);
        rstN = 1'b0;
        #1;
        compared++; if (controlReg !== 16'h0001 || rxReady !== 1'b0 || wbStbO !== 1'b0) begin mismatched++; $display("FAIL midrst_async: got ctrl %04h rxReady %0b stb %0b want 0001 0 0", controlReg, rxReady, wbStbO); end
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (txValid !== 1'b0 || wbStbO !== 1'b0) txBad++;
        end
        compared++; if (txBad !== 0) begin mismatched++; $display("FAIL midrst_quiet: %0d cycles with tx/stb activity, want 0", txBad); end
        statusReg = 16'hA5C3;
        sendByte(8'h53);
        recvBytes(2, got, cnt);
        compared++; if (cnt !== 2 || got !== 16'hA5C3) begin mismatched++; $display("FAIL midrst_status: got %0d bytes %04h want 2 bytes a5c3", cnt, got); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_control_status();
        test_timeout();
        test_unknown_and_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/host_loader.md
# host_loader

Host-side command front end of the tester. Parses a byte stream from the host link (UART receiver or equivalent), issues single Wishbone read/write cycles to program and register memory, owns the 16-bit `controlReg` that drives the test processor, and returns `statusReg` and read data as reply bytes. It sits upstream of the processor: it loads the program, releases halt, and polls completion.

## Interface
- `ADDRESS_WIDTH`, 24: Wishbone address width, ≤ 24.
- `ACK_TIMEOUT`, 255: cycles to wait for `wbAckI` before abandoning a cycle, ≥ 1.
- `CONTROL_RESET`, 16'h0001: reset value of `controlReg` (processor halted).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `rxData` in 8: host byte in.
- `rxValid` in 1: `rxData` valid.
- `rxReady` out 1: byte accepted when `rxValid && rxReady`.
- `txData` out 8: reply byte.
- `txValid` out 1: reply byte valid.
- `txReady` in 1: reply byte consumed when `txValid && txReady`.
- `wbAdrO` out ADDRESS_WIDTH: Wishbone address.
- `wbDatO` out 16: write data.
- `wbDatI` in 16: read data.
- `wbCycO`, `wbStbO`, `wbWeO` out 1: Wishbone master controls. `wbCycO` always equals `wbStbO`.
- `wbAckI` in 1: slave acknowledge.
- `controlReg` out 16: register driving the processor; bit 0 is halt.
- `statusReg` in 16: processor status, sampled when replying.

## Operation
- Frames are an opcode byte followed by big-endian argument bytes:
  - `'W'` 0x57 + addr[23:16], addr[15:8], addr[7:0], data[15:8], data[7:0] → Wishbone write; reply 0x4B `'K'`.
  - `'R'` 0x52 + 3 address bytes → Wishbone read; reply data[15:8], data[7:0].
  - `'C'` 0x43 + hi, lo → `controlReg` <= {hi, lo}; reply `'K'`.
  - `'S'` 0x53 → reply statusReg[15:8], statusReg[7:0]. Both bytes come from one sample, taken on the cycle the first reply byte is loaded.
  - Any other opcode → reply 0x3F `'?'`. Nothing is consumed beyond the opcode.
- The address is the low ADDRESS_WIDTH bits of the 24-bit assembled value. Upper bits are discarded silently.
- Wishbone timeout: a free-running 8+ bit counter clears on cycle start. If it reaches ACK_TIMEOUT with no ack, the block drops cyc/stb/we and replies 0x45 `'E'` in place of the normal reply. `'R'` sends only `'E'` (1 byte).
- FSM states:
  - IDLE: `rxReady`=1. An opcode byte goes to ARGS, or to REPLY for `'S'` and unknown opcodes.
  - ARGS: `rxReady`=1. A byte counter counts the remaining arguments. On the last byte: `'C'` → REPLY; `'W'`/`'R'` → BUS.
  - BUS: `rxReady`=0. Cycle held until ack or timeout, then → REPLY.
  - REPLY: `rxReady`=0. Sends 1 or 2 bytes, then → IDLE.
- There is no inter-byte timeout. A partial frame waits indefinitely.

## Timing
- Reset (rstN low, asynchronous):
  - `rxReady`=0, `txValid`=0, `txData`=0.
  - `wbCycO`/`wbStbO`/`wbWeO`=0, `wbAdrO`=0, `wbDatO`=0.
  - `controlReg`=CONTROL_RESET.
  - FSM in IDLE. `rxReady` rises on the first clock after release.
- Wishbone cycle start: `wbCycO`/`wbStbO` (and `wbWeO` for `'W'`) assert on the cycle after the last argument byte is accepted, with `wbAdrO`/`wbDatO` stable.
- Wishbone cycle end: all three deassert the cycle after `wbAckI` is sampled high. `wbDatI` is captured on that same edge.
- Zero-wait slave (ack on the first stb cycle): one bus cycle, then `txValid` rises the following cycle.
- `'C'`: `controlReg` updates on the edge that accepts the lo byte. `txValid` rises the next cycle.
- `txData`/`txValid` are held stable until `txReady`. The second reply byte is presented the cycle after the first is taken. After the last byte, IDLE is re-entered, with `rxReady`=1 on the following cycle.
- An ack arriving on the same cycle the timeout count is reached counts as success.
- `wbAckI` asserted outside BUS is ignored.
- Reset mid-cycle drops cyc/stb at once and abandons any reply in progress. `controlReg` returns to CONTROL_RESET, halting the processor.

## Test plan
- Reset: hold rstN low for 3 cycles → all outputs at reset values, `controlReg`=0x0001. Release → `rxReady`=1 after one clock.
- Write: bytes 57 01 00 05 12 34; slave acks on its 2nd stb cycle → one cycle with adr=0x010005, dat=0x1234, we=1, stb held 2 cycles; then reply 4B.
- Read, with tx back-pressure: bytes 52 00 00 07; slave returns 0xBEEF; hold `txReady` low for 5 cycles → `txData`=BE held for 5 cycles, then BE, EF sent in order.
- Control and status: bytes 43 00 00 → `controlReg`=0x0000, reply 4B. Set `statusReg`=0x0005 then send 53 → reply 00 05.
- Timeout: ACK_TIMEOUT=4, slave never acks, bytes 52 00 00 00 → stb high for exactly 4 cycles, then dropped; reply 45.
- Unknown opcode and mid-frame reset:
  - Send 99 → reply 3F, then `rxReady`=1.
  - Send 57 01 and pulse rstN low → no reply. A following 53 frame still parses correctly.
